// File: rtl/uc_mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier control unit.
package uc_mult_pkg;

    // Default multiplier width, which is also the number of iterations
    localparam int unsigned MULT_N     = 3;
    localparam int unsigned MULT_CNT_W = $clog2(MULT_N + 1);

    // 3-bit FSM state codes; codes 6 and 7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/contador_it.sv
// Iteration down-counter: loads N at the start of a run, decrements once per shift.
module contador_it #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic             decr,
    output logic [CNT_W-1:0] cuenta
);

    // Load has priority; decrement is only requested while cuenta >= 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= CNT_W'(N);
        end else if (decr) begin
            cuenta <= cuenta - CNT_W'(1);
        end
    end

endmodule

// File: rtl/uc_mult_ctrl.sv
// Hardwired Moore control unit for the shift-and-add multiplier datapath.
module uc_mult_ctrl
    import uc_mult_pkg::*;
#(
    parameter int unsigned N     = MULT_N,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inicio,
    input  logic q0,
    output logic CargaM,
    output logic CargaQ,
    output logic BorraA,
    output logic CargaA,
    output logic DesplazaA,
    output logic DesplazaQ,
    output logic fin
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cuenta;
    logic               cnt_carga;
    logic               cnt_decr;

    assign cnt_carga = (state_q == ST_LOAD);
    assign cnt_decr  = (state_q == ST_SHIFT);

    contador_it #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .carga  (cnt_carga),
        .decr   (cnt_decr),
        .cuenta (cuenta)
    );

    // State register; async reset forces IDLE so every command drops at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore output decode from the state register only
    always_comb begin
        state_d   = state_q;
        CargaM    = 1'b0;
        CargaQ    = 1'b0;
        BorraA    = 1'b0;
        CargaA    = 1'b0;
        DesplazaA = 1'b0;
        DesplazaQ = 1'b0;
        fin       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inicio) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                CargaM  = 1'b1;
                CargaQ  = 1'b1;
                BorraA  = 1'b1;
                state_d = ST_TEST;
            end
            ST_TEST: begin
                // q0 settled here: Q last changed on the edge entering TEST
                state_d = q0 ? ST_ADD : ST_SHIFT;
            end
            ST_ADD: begin
                CargaA  = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                DesplazaA = 1'b1;
                DesplazaQ = 1'b1;
                // cuenta holds the pre-decrement value in this cycle
                state_d   = (cuenta == CNT_W'(1)) ? ST_DONE : ST_TEST;
            end
            ST_DONE: begin
                fin = 1'b1;
                if (!inicio) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uc_mult_ctrl.sv
// Directed self-checking bench for uc_mult_ctrl with a behavioural A/Q/M datapath.
module tb_uc_mult_ctrl;
    import uc_mult_pkg::*;

    localparam int unsigned N = MULT_N;

    // Output vector order: {CargaM,CargaQ,BorraA,CargaA,DesplazaA,DesplazaQ,fin}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_LOAD  = 7'b1110000;
    localparam logic [6:0] V_TEST  = 7'b0000000;
    localparam logic [6:0] V_ADD   = 7'b0001000;
    localparam logic [6:0] V_SHIFT = 7'b0000110;
    localparam logic [6:0] V_DONE  = 7'b0000001;

    logic clk = 1'b0;
    logic reset;
    logic inicio;
    logic q0;
    logic CargaM, CargaQ, BorraA, CargaA, DesplazaA, DesplazaQ, fin;
    logic [6:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural datapath: A carries one extra bit for the add carry
    logic [N-1:0] mcand = '0;
    logic [N-1:0] mult  = '0;
    logic [N-1:0] m_reg = '0;
    logic [N-1:0] q_reg = '0;
    logic [N:0]   a_reg = '0;

    assign q0   = q_reg[0];
    assign outs = {CargaM, CargaQ, BorraA, CargaA, DesplazaA, DesplazaQ, fin};

    uc_mult_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .inicio    (inicio),
        .q0        (q0),
        .CargaM    (CargaM),
        .CargaQ    (CargaQ),
        .BorraA    (BorraA),
        .CargaA    (CargaA),
        .DesplazaA (DesplazaA),
        .DesplazaQ (DesplazaQ),
        .fin       (fin)
    );

    always #5 clk = ~clk;

    // Datapath registers respond to the commands on the rising edge
    always @(posedge clk) begin
        if (CargaM) m_reg <= mcand;
        if (CargaQ) q_reg <= mult;
        if (BorraA) begin
            a_reg <= '0;
        end else if (CargaA) begin
            a_reg <= a_reg + {1'b0, m_reg};
        end else if (DesplazaA) begin
            {a_reg, q_reg} <= {a_reg, q_reg} >> 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Command exclusivity and fin/DONE correspondence, checked every cycle
    always @(negedge clk) begin
        chk("excl_q", 32'(CargaQ & DesplazaQ), 32'd0);
        chk("excl_a", 32'($countones({CargaA, DesplazaA, BorraA}) > 1), 32'd0);
        chk("shift_pair", 32'(DesplazaA ^ DesplazaQ), 32'd0);
        chk("fin_only_done", 32'(fin && (dut.state_q != ST_DONE)), 32'd0);
    end

    // Start a run from IDLE (called at a falling edge) and check every cycle up to fin.
    // Cycle 1 is the LOAD cycle right after the inicio-sampling edge.
    task automatic run_mult(input logic [N-1:0] mc, input logic [N-1:0] mp,
                            input bit hold, input string tag);
        logic [6:0] exp_q[$];
        int cyc, lat, n_add, n_shq;
        exp_q = {};
        exp_q.push_back(V_LOAD);
        for (int i = 0; i < int'(N); i++) begin
            exp_q.push_back(V_TEST);
            if (mp[i]) exp_q.push_back(V_ADD);
            exp_q.push_back(V_SHIFT);
        end
        exp_q.push_back(V_DONE);
        mcand  = mc;
        mult   = mp;
        inicio = 1'b1;
        cyc = 0; lat = 0; n_add = 0; n_shq = 0;
        while (lat == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) inicio = 1'b0;
            if (cyc <= exp_q.size())
                chk($sformatf("%s_cyc%0d", tag, cyc), 32'(outs), 32'(exp_q[cyc-1]));
            n_add += int'(CargaA);
            n_shq += int'(DesplazaQ);
            if (fin) lat = cyc;
        end
        chk({tag, "_latency"}, lat, 2 + 2 * N + $countones(mp));
        chk({tag, "_adds"}, n_add, $countones(mp));
        chk({tag, "_shifts"}, n_shq, N);
        chk({tag, "_product"}, 32'({a_reg, q_reg}), 32'(mc) * 32'(mp));
    endtask

    // Start a run and stop at the falling edge where the count-th pulse is seen
    task automatic run_until(input logic [N-1:0] mp, input bit on_add,
                             input int count, input string tag);
        int seen, cyc;
        mult   = mp;
        inicio = 1'b1;
        seen = 0; cyc = 0;
        while (seen < count && cyc < 30) begin
            @(negedge clk);
            cyc++;
            inicio = 1'b0;
            if (on_add ? CargaA : DesplazaQ) seen++;
        end
        chk({tag, "_reached"}, seen, count);
    endtask

    initial begin
        reset  = 1'b1;
        inicio = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'(outs), 32'(V_IDLE));
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("post_rst_outs", 32'(outs), 32'(V_IDLE));

        // Reset pulse while idle
        #2 reset = 1'b1;
        #1 chk("rst_idle_outs", 32'(outs), 32'(V_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_idle_state", 32'(dut.state_q), 32'(ST_IDLE));

        // Reset in the middle of a SHIFT cycle
        mcand = 3'd5;
        run_until(3'b110, 1'b0, 1, "to_shift");
        chk("in_shift", 32'(outs), 32'(V_SHIFT));
        reset = 1'b1;
        #1 chk("rst_shift_outs", 32'(outs), 32'(V_IDLE));
        chk("rst_shift_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("quiet_after_rst%0d", k), 32'(outs), 32'(V_IDLE));
        end

        // Multiplier 000: no adds, fin in cycle 8
        run_mult(3'd5, 3'b000, 1'b0, "m000");
        @(negedge clk);
        chk("m000_back_idle", 32'(outs), 32'(V_IDLE));

        // Multiplier 101: two adds, fin in cycle 10
        run_mult(3'd6, 3'b101, 1'b0, "m101");
        @(negedge clk);
        chk("m101_back_idle", 32'(outs), 32'(V_IDLE));

        // Multiplier 111 with inicio held: fin in cycle 11, then holds in DONE
        run_mult(3'd7, 3'b111, 1'b1, "m111");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold_done%0d", k), 32'(outs), 32'(V_DONE));
        end
        inicio = 1'b0;
        @(negedge clk);
        chk("drop_idle_outs", 32'(outs), 32'(V_IDLE));
        chk("drop_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
        run_mult(3'd3, 3'b010, 1'b0, "rerun");
        @(negedge clk);

        // Reset in the ADD of the second iteration, then a clean run
        mcand = 3'd4;
        run_until(3'b011, 1'b1, 2, "to_add2");
        chk("in_add2", 32'(outs), 32'(V_ADD));
        reset = 1'b1;
        #1 chk("rst_add_outs", 32'(outs), 32'(V_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_add_quiet", 32'(outs), 32'(V_IDLE));
        run_mult(3'd5, 3'b011, 1'b0, "m011");
        @(negedge clk);
        chk("m011_back_idle", 32'(outs), 32'(V_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
